// File: rtl/audio_arbiter.sv
// Priority arbiter that routes one of N_CH PWM sound players to the amplifier.
// Requests are rising edges on req. Playback may be preempted, and a silent gap follows each sound.
module audio_arbiter #(
    parameter int N_CH    = 3,
    parameter int GAP_CYC = 4,
    parameter int MAX_CYC = 16,
    parameter int PREEMPT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CH-1:0]           req,
    input  logic [N_CH-1:0]           ch_pwm,
    input  logic [N_CH-1:0]           ch_done,
    output logic [N_CH-1:0]           grant,
    output logic [$clog2(N_CH)-1:0]   cur_ch,
    output logic                      busy,
    output logic                      pmod_1,
    output logic                      pmod_2,
    output logic                      pmod_4
);

    localparam int CH_W  = $clog2(N_CH);
    localparam int TMR_W = $clog2((MAX_CYC > GAP_CYC) ? MAX_CYC : GAP_CYC) + 1;

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t            state;
    logic [N_CH-1:0]   req_q;
    logic [N_CH-1:0]   edge_p1;
    logic [N_CH-1:0]   pending;
    logic [TMR_W-1:0]  timer;

    logic [CH_W-1:0]   top;
    logic              any_pend;
    logic              preempt_hit;
    logic              done_hit;
    logic              take;
    logic [N_CH-1:0]   clr;

    function automatic logic [CH_W-1:0] hi_idx(input logic [N_CH-1:0] v);
        hi_idx = '0;
        for (int i = 0; i < N_CH; i++)
            if (v[i]) hi_idx = CH_W'(i);
    endfunction

    function automatic logic [N_CH-1:0] onehot(input logic [CH_W-1:0] idx);
        onehot = N_CH'(1) << idx;
    endfunction

    always_comb begin
        top         = hi_idx(pending);
        any_pend    = |pending;
        preempt_hit = (PREEMPT != 0) && any_pend && (top > cur_ch);
        done_hit    = ch_done[cur_ch];
        take        = ((state == IDLE) && any_pend) || ((state == PLAY) && preempt_hit);
        clr         = take ? onehot(top) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            req_q   <= '0;
            edge_p1 <= '0;
            pending <= '0;
            timer   <= '0;
            grant   <= '0;
            cur_ch  <= '0;
            busy    <= 1'b0;
            pmod_1  <= 1'b0;
            pmod_2  <= 1'b1;
            pmod_4  <= 1'b0;
        end else begin
            // edge detect -> edge_p1 -> pending; a set on the same cycle as a grant keeps the re-trigger
            req_q   <= req;
            edge_p1 <= req & ~req_q;
            pending <= (pending & ~clr) | edge_p1;
            pmod_2  <= 1'b1;
            case (state)
                IDLE: begin
                    pmod_1 <= 1'b0;
                    if (any_pend) begin
                        state  <= PLAY;
                        grant  <= onehot(top);
                        cur_ch <= top;
                        timer  <= '0;
                        busy   <= 1'b1;
                        pmod_4 <= 1'b1;
                        pmod_1 <= ch_pwm[top];
                    end
                end
                PLAY: begin
                    if (preempt_hit) begin
                        grant  <= onehot(top);
                        cur_ch <= top;
                        timer  <= '0;
                        pmod_1 <= ch_pwm[top];
                    end else if (done_hit || (timer == TMR_W'(MAX_CYC - 1))) begin
                        state  <= GAP;
                        grant  <= '0;
                        cur_ch <= '0;
                        timer  <= '0;
                        pmod_1 <= 1'b0;
                    end else begin
                        timer  <= timer + 1'b1;
                        pmod_1 <= ch_pwm[cur_ch];
                    end
                end
                GAP: begin
                    pmod_1 <= 1'b0;
                    if (timer == TMR_W'(GAP_CYC - 1)) begin
                        state  <= IDLE;
                        timer  <= '0;
                        busy   <= 1'b0;
                        pmod_4 <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    grant  <= '0;
                    cur_ch <= '0;
                    timer  <= '0;
                    busy   <= 1'b0;
                    pmod_1 <= 1'b0;
                    pmod_4 <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/audio_arbiter.md
AUDIO_ARBITER -- requirements
Module: audio_arbiter

Interface
REQ-001 Parameter N_CH, default 3: number of sound channels, range 2..16.
REQ-002 Parameter GAP_CYC, default 4: silent cycles inserted after each sound, range 1..2^16.
REQ-003 Parameter MAX_CYC, default 16: maximum cycles one channel may hold the output, range 2..2^24.
REQ-004 Parameter PREEMPT, default 1: 1 means a higher-priority request interrupts playback; 0 means it waits.
REQ-005 One clock; reset is synchronous and active-high. Ports clk and rst.
REQ-006 clk  in  1  system clock; all state updates on its rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 req  in  N_CH  per-channel play trigger; a rising edge is a request.
REQ-009 ch_pwm  in  N_CH  per-channel PWM audio from the channel players.
REQ-010 ch_done  in  N_CH  per-channel end-of-sound flag, sampled only for the granted channel.
REQ-011 grant  out  N_CH  one-hot level; drives the play input of the selected player.
REQ-012 cur_ch  out  clog2(N_CH)  index of the granted channel; 0 when none is granted.
REQ-013 busy  out  1  high whenever the state is not IDLE.
REQ-014 pmod_1  out  1  audio PWM to the amplifier.
REQ-015 pmod_2  out  1  amplifier gain select.
REQ-016 pmod_4  out  1  amplifier shutdown_n.

Function
REQ-017 Edge detection: req_q SHALL register req each cycle; a channel's edge is req & ~req_q.
REQ-018 Pending latch: an edge SHALL set that channel's pending bit in the following cycle.
REQ-019 A pending bit SHALL clear on the cycle its channel is granted.
REQ-020 If a channel's set and clear coincide, set SHALL win (the re-trigger stays queued).
REQ-021 Priority: a higher channel index SHALL have higher priority.
REQ-022 The FSM SHALL have exactly three states: IDLE, PLAY and GAP.
REQ-023 IDLE: with any pending bit set, the next state SHALL be PLAY, granting the highest pending channel and loading the timer to 0.
REQ-024 Latency: a req rising edge sampled at edge k while IDLE SHALL produce grant high after edge k+2.
REQ-025 PLAY: the timer SHALL increment once per cycle.
REQ-026 PLAY: ch_done of the granted channel, or timer == MAX_CYC-1, SHALL move the FSM to GAP and clear grant.
REQ-027 PLAY with PREEMPT=1: a pending channel of higher priority than cur_ch SHALL take the grant on the next cycle, restart the timer at 0 and clear its own pending bit.
REQ-028 On preemption, the interrupted channel SHALL be dropped, not re-queued; there is no GAP between the two sounds.
REQ-029 PLAY with PREEMPT=0: higher-priority requests SHALL remain pending until IDLE.
REQ-030 Preemption SHALL take precedence over ch_done or timeout on the same cycle.
REQ-031 ch_done SHALL be ignored on non-granted channels and in IDLE and GAP.
REQ-032 GAP: the FSM SHALL stay in GAP for exactly GAP_CYC cycles, then enter IDLE.
REQ-033 Requests SHALL keep latching in every state.
REQ-034 pmod_1 SHALL be the registered value of ch_pwm[cur_ch] in PLAY and 0 otherwise (one-cycle delay).
REQ-035 pmod_2 SHALL be constant 1.
REQ-036 pmod_4 SHALL be 1 in PLAY and GAP and 0 in IDLE.
REQ-037 All outputs SHALL be registered and free of combinational paths from inputs.

Reset
REQ-038 With rst high at a clock edge, the block SHALL set: state IDLE, pending 0, req_q 0, timer 0, grant 0, cur_ch 0, busy 0, pmod_1 0, pmod_4 0, pmod_2 1.
REQ-039 A req held high through reset release SHALL count as one rising edge.
REQ-040 Reset asserted during PLAY or GAP SHALL abort the sound; the outputs SHALL hold their REQ-038 values from the next edge.
REQ-041 Requests that arrive while rst is high SHALL be discarded.

Verification (N_CH=3, GAP_CYC=4, MAX_CYC=16)
REQ-042 Single request: req[0] pulses at cycle 10 -> grant=001 from cycle 12; ch_done[0] at cycle 20 -> grant=000 and GAP for cycles 21..24; IDLE at cycle 25 with pmod_4 falling to 0.
REQ-043 Simultaneous requests: req=011 at one edge -> channel 1 plays first; channel 0 is granted immediately after the GAP following channel 1's done.
REQ-044 Preemption: during channel 0 playback, req[2] rises -> grant=100 two cycles later with no gap, and channel 0 never replays; with PREEMPT=0, channel 2 plays after channel 0 plus GAP.
REQ-045 Timeout: ch_done never asserts -> grant drops after exactly 16 PLAY cycles and GAP is entered.
REQ-046 Audio path: ch_pwm[1] toggles every cycle while channel 1 is granted -> pmod_1 equals that toggle delayed by one cycle; pmod_1 is 0 in GAP even while ch_pwm stays active.
REQ-047 Reset: rst mid-PLAY with req[1] also held high -> all outputs reach reset values next edge; after rst falls, channel 1 is granted exactly once.
